// File: rtl/rst_seq_pkg.sv
// ----------------------------------------------------------------------------
// rst_seq_pkg
//   Shared definitions for the staged reset sequencer: FSM state encodings
//   (also exported on oState for debug) and the counter-width helper.
// ----------------------------------------------------------------------------
package rst_seq_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_LOST      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_RELEASE   = ST_RELEASE,
        S_RUN       = ST_RUN,
        S_LOST      = ST_LOST
    } state_t;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cntW(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl_if
//   Control/status bundle of the staged reset sequencer.
//   Signals:
//     iPllLocked   PLL lock, asynchronous to the sequencer clock
//     iSoftRst     synchronous level soft reset, active-high
//     oStageRst    per-stage reset, active-high, bit 0 released first
//     oAllReady    all stages released
//     oLockTimeout sticky lock-timeout flag
//     oState       current sequencer state (debug)
//   Modports: master (clock/reset source side), slave (the sequencer).
// ----------------------------------------------------------------------------
interface rst_seq_ctrl_if #(
    parameter int pStageNum = 4
);
    import rst_seq_pkg::*;

    logic                 iPllLocked;
    logic                 iSoftRst;
    logic [pStageNum-1:0] oStageRst;
    logic                 oAllReady;
    logic                 oLockTimeout;
    state_t               oState;

    modport master (
        output iPllLocked, iSoftRst,
        input  oStageRst, oAllReady, oLockTimeout, oState
    );

    modport slave (
        input  iPllLocked, iSoftRst,
        output oStageRst, oAllReady, oLockTimeout, oState
    );

endinterface

// File: rtl/rst_seq_sync.sv
// ----------------------------------------------------------------------------
// rst_seq_sync
//   Two-flop synchronizer for a single asynchronous level, cleared to 0 by
//   the asynchronous active-low reset.
//   Ports:
//     iSysClk   destination clock
//     iSysRstN  asynchronous active-low clear
//     iAsync    asynchronous input level
//     oSync     synchronized level (2 cycles of latency)
// ----------------------------------------------------------------------------
module rst_seq_sync (
    input  logic iSysClk,
    input  logic iSysRstN,
    input  logic iAsync,
    output logic oSync
);

    logic rMeta_p0;
    logic rSync_p1;

    always_ff @(posedge iSysClk or negedge iSysRstN) begin
        if (!iSysRstN) begin
            rMeta_p0 <= 1'b0;
            rSync_p1 <= 1'b0;
        end else begin
            // stage p0: may go metastable; stage p1: settled copy
            rMeta_p0 <= iAsync;
            rSync_p1 <= rMeta_p0;
        end
    end

    assign oSync = rSync_p1;

endmodule

// File: rtl/rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl
//   Staged reset sequencer. Waits for a stable synchronized PLL lock, then
//   releases the per-subsystem resets one at a time in ascending order,
//   pStageGapCyc cycles apart, and flags oAllReady once all are released.
//   Any soft reset (or loss of lock, when enabled) reasserts all stages at
//   once. A lock that does not become stable within pLockTimeoutCyc cycles of
//   waiting raises the sticky oLockTimeout flag; waiting continues.
//   Ports:
//     iSysClk   system clock (only clock)
//     iSysRstN  asynchronous active-low reset
//     bus       rst_seq_ctrl_if.slave: iPllLocked, iSoftRst in;
//               oStageRst, oAllReady, oLockTimeout, oState out (all registered)
//   Build option:
//     RST_SEQ_LOCK_LOSS_EN  when defined, lock loss during RELEASE/RUN
//                           reasserts all stages and passes through LOST for
//                           pStageGapCyc cycles before waiting for lock again.
//                           When undefined, lock is only watched in WAIT_LOCK.
// ----------------------------------------------------------------------------
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int pStageNum       = 4,
    parameter int pLockStableCyc  = 1024,
    parameter int pStageGapCyc    = 16,
    parameter int pLockTimeoutCyc = 65535
) (
    input  logic          iSysClk,
    input  logic          iSysRstN,
    rst_seq_ctrl_if.slave bus
);

    localparam int STABLE_W = cntW(pLockStableCyc);
    localparam int GAP_W    = cntW(pStageGapCyc);
    localparam int TO_W     = cntW(pLockTimeoutCyc);
    localparam int IDX_W    = cntW(pStageNum);

    localparam logic [STABLE_W-1:0]  STABLE_LAST = STABLE_W'(pLockStableCyc - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST    = GAP_W'(pStageGapCyc - 1);
    localparam logic [TO_W-1:0]      TO_LAST     = TO_W'(pLockTimeoutCyc - 1);
    localparam logic [TO_W-1:0]      TO_MAX      = TO_W'(pLockTimeoutCyc);
    localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(pStageNum - 1);
    localparam logic [pStageNum-1:0] STAGE_ONE   = pStageNum'(1);

    logic wLockS;

    state_t               rState,      stateNxt;
    logic [pStageNum-1:0] rStageRst,   stageRstNxt;
    logic                 rAllReady,   allReadyNxt;
    logic                 rLockTo,     lockToNxt;
    logic [STABLE_W-1:0]  rStableCnt,  stableCntNxt;
    logic [GAP_W-1:0]     rGapCnt,     gapCntNxt;
    logic [TO_W-1:0]      rToCnt,      toCntNxt;
    logic [IDX_W-1:0]     rStageIdx,   stageIdxNxt;

    rst_seq_sync uLockSync (
        .iSysClk  (iSysClk),
        .iSysRstN (iSysRstN),
        .iAsync   (bus.iPllLocked),
        .oSync    (wLockS)
    );

    always_ff @(posedge iSysClk or negedge iSysRstN) begin
        if (!iSysRstN) begin
            rState     <= S_IDLE;
            rStageRst  <= '1;
            rAllReady  <= 1'b0;
            rLockTo    <= 1'b0;
            rStableCnt <= '0;
            rGapCnt    <= '0;
            rToCnt     <= '0;
            rStageIdx  <= '0;
        end else begin
            rState     <= stateNxt;
            rStageRst  <= stageRstNxt;
            rAllReady  <= allReadyNxt;
            rLockTo    <= lockToNxt;
            rStableCnt <= stableCntNxt;
            rGapCnt    <= gapCntNxt;
            rToCnt     <= toCntNxt;
            rStageIdx  <= stageIdxNxt;
        end
    end

    always_comb begin
        stateNxt     = rState;
        stageRstNxt  = rStageRst;
        allReadyNxt  = rAllReady;
        lockToNxt    = rLockTo;
        stableCntNxt = rStableCnt;
        gapCntNxt    = rGapCnt;
        toCntNxt     = rToCnt;
        stageIdxNxt  = rStageIdx;

        case (rState)
            S_IDLE: begin
                stageRstNxt = '1;
                allReadyNxt = 1'b0;
                stateNxt    = S_WAIT_LOCK;
            end

            S_WAIT_LOCK: begin
                // Timeout counter keeps running across lock glitches and
                // saturates; the flag is raised on the cycle it hits the limit.
                if (rToCnt != TO_MAX) begin
                    toCntNxt = rToCnt + TO_W'(1);
                end
                if (rToCnt >= TO_LAST) begin
                    lockToNxt = 1'b1;
                end
                if (wLockS) begin
                    if (rStableCnt == STABLE_LAST) begin
                        stableCntNxt   = '0;
                        stageRstNxt[0] = 1'b0;
                        stageIdxNxt    = '0;
                        gapCntNxt      = '0;
                        stateNxt       = S_RELEASE;
                    end else begin
                        stableCntNxt = rStableCnt + STABLE_W'(1);
                    end
                end else begin
                    stableCntNxt = '0;
                end
            end

            S_RELEASE: begin
                if (rStageIdx == IDX_LAST) begin
                    // Only reachable for a single-stage build: stage 0 was the last.
                    gapCntNxt   = '0;
                    allReadyNxt = 1'b1;
                    stateNxt    = S_RUN;
                end else if (rGapCnt == GAP_LAST) begin
                    gapCntNxt   = '0;
                    stageIdxNxt = rStageIdx + IDX_W'(1);
                    stageRstNxt = rStageRst & ~(STAGE_ONE << stageIdxNxt);
                    if (stageIdxNxt == IDX_LAST) begin
                        stateNxt = S_RUN;
                    end
                end else begin
                    gapCntNxt = rGapCnt + GAP_W'(1);
                end
            end

            S_RUN: begin
                stageRstNxt = '0;
                allReadyNxt = 1'b1;
            end

`ifdef RST_SEQ_LOCK_LOSS_EN
            S_LOST: begin
                stageRstNxt = '1;
                allReadyNxt = 1'b0;
                if (rGapCnt == GAP_LAST) begin
                    gapCntNxt    = '0;
                    stableCntNxt = '0;
                    stateNxt     = S_WAIT_LOCK;
                end else begin
                    gapCntNxt = rGapCnt + GAP_W'(1);
                end
            end
`endif

            default: begin
                stageRstNxt = '1;
                allReadyNxt = 1'b0;
                stateNxt    = S_IDLE;
            end
        endcase

`ifdef RST_SEQ_LOCK_LOSS_EN
        if ((rState == S_RELEASE || rState == S_RUN) && !wLockS) begin
            stateNxt     = S_LOST;
            stageRstNxt  = '1;
            allReadyNxt  = 1'b0;
            stableCntNxt = '0;
            gapCntNxt    = '0;
            stageIdxNxt  = '0;
        end
`endif

        // Soft reset overrides everything, including lock loss and timeout.
        if (bus.iSoftRst) begin
            stateNxt     = S_IDLE;
            stageRstNxt  = '1;
            allReadyNxt  = 1'b0;
            lockToNxt    = 1'b0;
            stableCntNxt = '0;
            gapCntNxt    = '0;
            toCntNxt     = '0;
            stageIdxNxt  = '0;
        end
    end

    assign bus.oStageRst    = rStageRst;
    assign bus.oAllReady    = rAllReady;
    assign bus.oLockTimeout = rLockTo;
    assign bus.oState       = rState;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rst_seq_ctrl
//   Directed bench for rst_seq_ctrl with 4 stages, 8-cycle lock qualification,
//   4-cycle stage gap and 32-cycle lock timeout. Expected output transitions
//   are queued with the clock cycle they must appear on and checked as the
//   DUT produces them.
// ----------------------------------------------------------------------------
module tb_rst_seq_ctrl;
    import rst_seq_pkg::*;

    localparam int NS     = 4;
    localparam int STABLE = 8;
    localparam int GAP    = 4;
    localparam int TO     = 32;
    localparam int BUDGET = 200;

    logic iSysClk = 1'b0;
    logic iSysRstN;

    rst_seq_ctrl_if #(.pStageNum(NS)) bus ();

    rst_seq_ctrl #(
        .pStageNum       (NS),
        .pLockStableCyc  (STABLE),
        .pStageGapCyc    (GAP),
        .pLockTimeoutCyc (TO)
    ) dut (
        .iSysClk  (iSysClk),
        .iSysRstN (iSysRstN),
        .bus      (bus)
    );

    always #5 iSysClk = ~iSysClk;

    int cyc = 0;
    always @(posedge iSysClk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [NS-1:0] stg;
        logic          rdy;
    } ev_t;

    ev_t evQ[$];
    int  nVec = 0;
    int  nMis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushEv(input int c, input logic [NS-1:0] s, input logic r);
        ev_t e;
        e.cyc = c;
        e.stg = s;
        e.rdy = r;
        evQ.push_back(e);
    endtask

    // Full release sequence with stage 0 falling on cycle t0.
    task automatic pushSeq(input int t0);
        logic [NS-1:0] m;
        m = '1;
        for (int k = 0; k < NS; k++) begin
            m = m << 1;
            pushEv(t0 + k * GAP, m, 1'b0);
        end
        pushEv(t0 + (NS - 1) * GAP + 1, '0, 1'b1);
    endtask

    task automatic popCheck(input string tag);
        ev_t e;
        chk({tag, "_qnonempty"}, 32'(evQ.size() > 0), 32'd1);
        if (evQ.size() > 0) begin
            e = evQ.pop_front();
            chk({tag, "_cycle"}, cyc, e.cyc);
            chk({tag, "_stageRst"}, 32'(bus.oStageRst), 32'(e.stg));
            chk({tag, "_allReady"}, 32'(bus.oAllReady), 32'(e.rdy));
        end
    endtask

    // Waits (bounded) for each of the next n output changes and checks them.
    task automatic expectEvents(input string tag, input int n);
        logic [NS:0] prev;
        int          k;
        for (int i = 0; i < n; i++) begin
            prev = {bus.oStageRst, bus.oAllReady};
            k = 0;
            while ({bus.oStageRst, bus.oAllReady} === prev && k < BUDGET) begin
                @(negedge iSysClk);
                k++;
            end
            chk({tag, "_inbudget"}, 32'(k < BUDGET), 32'd1);
            popCheck(tag);
        end
    endtask

    task automatic waitTo(input int target);
        while (cyc < target) @(negedge iSysClk);
    endtask

    task automatic chkState(input string tag, input logic [2:0] exp);
        chk(tag, 32'(bus.oState), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int s;
        int d;

        bus.iPllLocked = 1'b0;
        bus.iSoftRst   = 1'b0;
        iSysRstN       = 1'b0;
        repeat (3) @(negedge iSysClk);

        // Reset values
        chkState("rst_state", ST_IDLE);
        chk("rst_stageRst", 32'(bus.oStageRst), 32'hF);
        chk("rst_allReady", 32'(bus.oAllReady), 32'd0);
        chk("rst_lockTo", 32'(bus.oLockTimeout), 32'd0);

        // 1: lock held high across reset release
        bus.iPllLocked = 1'b1;
        repeat (2) @(negedge iSysClk);
        iSysRstN = 1'b1;
        r = cyc;
        waitTo(r + 1);
        chkState("t1_wait", ST_WAIT_LOCK);
        pushSeq(r + 10);
        expectEvents("t1", NS + 1);
        chkState("t1_run", ST_RUN);

        // 2: lock glitch after 5 locked cycles restarts qualification
        iSysRstN       = 1'b0;
        bus.iPllLocked = 1'b0;
        @(negedge iSysClk);
        chk("t2_rst_stageRst", 32'(bus.oStageRst), 32'hF);
        iSysRstN = 1'b1;
        r = cyc;
        waitTo(r + 3);
        bus.iPllLocked = 1'b1;
        waitTo(r + 8);
        bus.iPllLocked = 1'b0;
        waitTo(r + 11);
        bus.iPllLocked = 1'b1;
        pushSeq(r + 21);
        expectEvents("t2", NS + 1);

        // 3: no lock for 40 cycles -> sticky timeout, then normal release
        iSysRstN       = 1'b0;
        bus.iPllLocked = 1'b0;
        @(negedge iSysClk);
        chk("t3_rst_lockTo", 32'(bus.oLockTimeout), 32'd0);
        iSysRstN = 1'b1;
        r = cyc;
        waitTo(r + TO);
        chk("t3_lockTo_before", 32'(bus.oLockTimeout), 32'd0);
        @(negedge iSysClk);
        chk("t3_lockTo_set", 32'(bus.oLockTimeout), 32'd1);
        waitTo(r + 40);
        bus.iPllLocked = 1'b1;
        pushSeq(r + 50);
        expectEvents("t3", NS + 1);
        chk("t3_lockTo_sticky", 32'(bus.oLockTimeout), 32'd1);
        chkState("t3_run", ST_RUN);

        // 4: soft reset in RUN, then again with stages 0-1 released
        s = cyc;
        bus.iSoftRst = 1'b1;
        pushEv(s + 1, 4'hF, 1'b0);
        @(negedge iSysClk);
        bus.iSoftRst = 1'b0;
        popCheck("t4_soft_run");
        chkState("t4_idle_a", ST_IDLE);
        chk("t4_lockTo_clr", 32'(bus.oLockTimeout), 32'd0);
        pushEv(s + 10, 4'hE, 1'b0);
        pushEv(s + 14, 4'hC, 1'b0);
        expectEvents("t4_part", 2);
        @(negedge iSysClk);
        s = cyc;
        bus.iSoftRst = 1'b1;
        pushEv(s + 1, 4'hF, 1'b0);
        @(negedge iSysClk);
        bus.iSoftRst = 1'b0;
        popCheck("t4_soft_rel");
        chkState("t4_idle_b", ST_IDLE);
        pushSeq(s + 10);
        expectEvents("t4_replay", NS + 1);

        // 5: lock loss while running
        d = cyc;
        bus.iPllLocked = 1'b0;
`ifdef RST_SEQ_LOCK_LOSS_EN
        pushEv(d + 3, 4'hF, 1'b0);
        expectEvents("t5_loss", 1);
        chkState("t5_lost_first", ST_LOST);
        waitTo(d + 6);
        chkState("t5_lost_last", ST_LOST);
        @(negedge iSysClk);
        chkState("t5_waitlock", ST_WAIT_LOCK);
        waitTo(d + 8);
        bus.iPllLocked = 1'b1;
        pushSeq(d + 18);
        expectEvents("t5_relock", NS + 1);
        chk("t5_lockTo", 32'(bus.oLockTimeout), 32'd0);
`else
        waitTo(d + 10);
        chk("t5_stageRst", 32'(bus.oStageRst), 32'h0);
        chk("t5_allReady", 32'(bus.oAllReady), 32'd1);
        chkState("t5_run", ST_RUN);
        bus.iPllLocked = 1'b1;
        waitTo(d + 14);
`endif

        // 6: asynchronous reset mid-RELEASE, then recovery
        s = cyc;
        bus.iSoftRst = 1'b1;
        pushEv(s + 1, 4'hF, 1'b0);
        @(negedge iSysClk);
        bus.iSoftRst = 1'b0;
        popCheck("t6_soft");
        pushEv(s + 10, 4'hE, 1'b0);
        expectEvents("t6_stage0", 1);
        @(negedge iSysClk);
        chkState("t6_release", ST_RELEASE);
        #3;
        iSysRstN = 1'b0;
        #1;
        chk("t6_async_stageRst", 32'(bus.oStageRst), 32'hF);
        chk("t6_async_allReady", 32'(bus.oAllReady), 32'd0);
        chkState("t6_async_state", ST_IDLE);
        repeat (2) @(negedge iSysClk);
        chkState("t6_held", ST_IDLE);
        iSysRstN = 1'b1;
        r = cyc;
        pushSeq(r + 10);
        expectEvents("t6_recover", NS + 1);
        chkState("t6_run", ST_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
